// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Round-robin scan with blanking dead-time, per-digit enable/dp and double-buffered data.
module seven_seg_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int ON_CYCLES        = 24000,
  parameter int BLANK_CYCLES     = 240,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          load,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0]         ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0]         BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_OFF     = (SEG_ACTIVE_LOW != 0);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx_n;
  logic                    boundary;

  logic [4*NUM_DIGITS-1:0] sh_val, act_val, act_val_n;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp, act_dp_n;
  logic [NUM_DIGITS-1:0]   sh_en, act_en, act_en_n;

  logic                    lit;
  logic [3:0]              nibble;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   anode_n;
  logic                    done_n;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = digit_idx;
    boundary = 1'b0;
    unique case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
        end
      end
      SHOW: begin
        if (cnt == ON_LAST) begin
          state_n  = (BLANK_CYCLES > 0) ? BLANK : SHOW;
          cnt_n    = '0;
          idx_n    = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
          boundary = (digit_idx == IDX_LAST);
        end
      end
    endcase
  end

  // A load coinciding with the frame boundary bypasses the shadow straight into the active set.
  always_comb begin
    act_val_n = act_val;
    act_dp_n  = act_dp;
    act_en_n  = act_en;
    if (boundary) begin
      act_val_n = load ? digits_in : sh_val;
      act_dp_n  = load ? dp_in     : sh_dp;
      act_en_n  = load ? digit_en  : sh_en;
    end
  end

  // Outputs are decoded from next-state values so anode and segments switch on one edge.
  always_comb begin
    nibble  = act_val_n[{idx_n, 2'b00} +: 4];
    lit     = (state_n == SHOW) && act_en_n[idx_n];
    seg_n   = lit ? glyph(nibble) : '0;
    dp_n    = lit & act_dp_n[idx_n];
    anode_n = lit ? (NUM_DIGITS'(1) << idx_n) : '0;
    done_n  = (state_n == SHOW) && (idx_n == IDX_LAST) && (cnt_n == ON_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= (BLANK_CYCLES > 0) ? BLANK : SHOW;
      cnt        <= '0;
      digit_idx  <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      anode      <= ANODE_OFF;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit_idx  <= idx_n;
      if (load) begin
        sh_val <= digits_in;
        sh_dp  <= dp_in;
        sh_en  <= digit_en;
      end
      act_val    <= act_val_n;
      act_dp     <= act_dp_n;
      act_en     <= act_en_n;
      anode      <= anode_n ^ ANODE_OFF;
      seg        <= seg_n ^ SEG_OFF;
      dp         <= dp_n ^ DP_OFF;
      frame_done <= done_n;
    end
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits sharing one segment bus.
- Replaces the two-digit anode toggle. Adds:
  - N-digit round-robin scan
  - programmable per-digit on-time
  - blanking dead-time between digits to suppress ghosting
  - per-digit enable and decimal point
  - double-buffered, tear-free digit updates
- Sits between the digit-value memory and the FPGA segment/anode pins. Runs on the 24 MHz HSOSC clock.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=2).
- ON_CYCLES, 24000, clk cycles each digit is lit per slot (>=1). The default gives 1 kHz per slot at 24 MHz.
- BLANK_CYCLES, 240, clk cycles all anodes are off before each digit's on-time (>=0; 0 means no blank phase).
- ANODE_ACTIVE_LOW, 1, 1 means anode asserted = 0.
- SEG_ACTIVE_LOW, 1, 1 means segment/dp lit = 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  hex value per digit; digit k = bits [4k+3:4k].
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  1 = digit k displayed, 0 = digit k kept dark.
- load  in  1  one-cycle strobe capturing digits_in/dp_in/digit_en into the shadow registers.
- seg  out  7  segments {g,f,e,d,c,b,a} (bit 6 = g), polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW.
- anode  out  NUM_DIGITS  digit select, one-hot or none, polarity per ANODE_ACTIVE_LOW.
- digit_idx  out  clog2(NUM_DIGITS)  index of the digit currently in its slot.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (synchronous, dominates all other inputs on the same edge):
  - state = BLANK, digit_idx = 0, slot counter = 0.
  - Shadow and active registers = 0 (values 0, dp 0, enables 0).
  - All anodes inactive, seg/dp all unlit, frame_done = 0.
- FSM states:
  - BLANK: lasts BLANK_CYCLES cycles. All anodes inactive, seg/dp unlit. Exit to SHOW.
  - If BLANK_CYCLES = 0, BLANK is never entered, including after reset: first cycle after reset is SHOW for digit 0.
  - SHOW: lasts ON_CYCLES cycles.
    - anode[digit_idx] active only if active_en[digit_idx] = 1.
    - seg = hex decode of active value[digit_idx]; dp = active_dp[digit_idx].
    - If the digit is disabled: anode stays inactive and seg/dp are unlit. Slot timing is unchanged.
  - On the last SHOW cycle: digit_idx increments, wrapping NUM_DIGITS-1 -> 0. Next state is BLANK (or SHOW if BLANK_CYCLES = 0).
- Frame period is exactly NUM_DIGITS*(BLANK_CYCLES+ON_CYCLES) cycles, with no extra idle cycles at wrap.
- All outputs are registered, derived from next-state. anode, seg, dp and digit_idx change on the same edge; no cycle shows a new anode with old segments.
- Hex decode: 0-F map to the standard glyphs 0123456789AbCdEF; 8 lights all seven segments. Polarity inversion is applied after decode.
- Double buffering:
  - load captures inputs into the shadow registers only.
  - The shadow is copied to the active registers on the frame boundary, i.e. the edge leaving digit NUM_DIGITS-1's last SHOW cycle.
  - A frame never mixes old and new data.
  - frame_done is high during that final SHOW cycle.
- Simultaneous load and frame boundary: digits_in/dp_in/digit_en go straight to the active registers (and the shadow) on that edge.
- Multiple loads within one frame: the last one wins.
- Worst-case latency from load to visible: one frame plus BLANK_CYCLES.
- Reset mid-scan: restarts at BLANK, digit 0. Pending shadow data is discarded.

Test Plan:
- Set NUM_DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=2; apply reset, then load 0x4321 with all enables set.
  - Required: anodes stay inactive 2 cycles, then anode[0] is active for 4 cycles with the glyph for 1, and so on for each digit.
  - Required: frame period is 24 cycles; frame_done pulses once per frame, on cycle 24 of the frame.
- Load 0x4321, then load 0xABCD mid-frame while digit 1 is shown.
  - Required: digits 2 and 3 still show 3 and 4; the next frame shows D, C, B, A.
  - Required: no frame ever contains a mix of old and new data.
- Apply digit_en = 4'b1010.
  - Required: anode[0] and anode[2] are never active and seg is unlit during their slots.
  - Required: the slot cadence still gives a 24-cycle frame.
- Assert load on the frame_done cycle.
  - Required: the new values appear on digit 0's first SHOW cycle of the immediately following frame.
- Assert reset during digit 2's SHOW.
  - Required: on the next edge all anodes go inactive and seg/dp go unlit, with digit_idx = 0.
  - Required: the scan then resumes with BLANK for digit 0, which stays dark until a new load.
- Set BLANK_CYCLES=0, ANODE_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0, and load 8 with dp set on digit 0.
  - Required: anode[0] = 1, seg = 7'b1111111, dp = 1.
  - Required: digits switch back-to-back with no blank gap, giving a 16-cycle frame.
